led_pattern_gen: RTL and testbench

Parametrised LED pattern engine for fabric-only board bring-up. It is the successor to the fixed 4-LED binary blinker. It drives NUM_LEDS outputs from a programmable tick prescaler and supports four runtime-selectable patterns, pause and single-step control, and global PWM brightness. It sits directly on the board LED pins, clocked by the 125 MHz fabric clock.

---
 rtl/led_pattern_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 38 +++
 rtl/led_pattern_gen.sv | 127 ++++++++++++
 tb/tb_led_pattern_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg
// Shared definitions for the LED pattern engine and its timer helpers.
//   mode_e  : pattern select encoding (binary, scan, gray, blink)
//   clog2w  : counter width helper, never narrower than one bit
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BIN   = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_GRAY  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  // Width able to hold values 0..value-1; a one-state counter still gets a bit.
  function automatic int clog2w(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Divides clk down to a pattern-advance strobe.
//   clk      : clock
//   rst      : synchronous reset, active-high (count returns to 0)
//   enable   : count while high, hold the count while low
//   clear    : synchronous restart of the count from 0
//   tick_out : high in the enabled cycle where the count sits at TICK_CYCLES-1,
//              giving exactly one strobe every TICK_CYCLES enabled cycles
module tick_prescaler
  import led_pattern_pkg::*;
#(
  parameter int TICK_CYCLES = 125000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick_out
);

  localparam int CNT_W = clog2w(TICK_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every register samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick_out = enable && (cnt == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
// Programmable LED pattern engine with prescaled auto-advance, single-step,
// four patterns and global PWM brightness.
//   clk    : fabric clock
//   rst    : synchronous reset, active-high
//   mode   : 0 binary, 1 scan (ping-pong one-hot), 2 gray, 3 blink
//   enable : auto-advance on prescaler strobe; 0 pauses
//   step   : one-cycle pulse advancing the pattern once while paused
//   bright : duty = bright / 2^PWM_BITS, saturating at 100%
//   led    : registered LED drive
//   tick   : registered one-cycle pulse marking each pattern advance
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS    = 4,
  parameter int TICK_CYCLES = 125000000,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                enable,
  input  logic                step,
  input  logic [PWM_BITS:0]   bright,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick
);

  localparam int POS_W = clog2w(NUM_LEDS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  mode_e                mode_q;
  logic [NUM_LEDS-1:0]  bin;      // counter for binary/gray, bit image for blink
  logic [POS_W-1:0]     pos;
  logic                 dir;      // 0 = moving up, 1 = moving down
  logic [PWM_BITS-1:0]  pwm_cnt;

  logic                 adv_auto;
  logic                 mode_change;
  logic                 adv;
  logic                 pwm_on;
  logic [NUM_LEDS-1:0]  pat;
  logic [POS_W-1:0]     pos_nxt;
  logic                 dir_nxt;

  assign mode_change = (mode != mode_q);

  tick_prescaler #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (mode_change),
    .tick_out (adv_auto)
  );

  // A mode change reloads the start value and swallows any coincident advance.
  assign adv    = (adv_auto || (step && !enable)) && !mode_change;
  assign pwm_on = ({1'b0, pwm_cnt} < bright);

  // Ping-pong: at either end reverse and step inward within the same advance.
  // NOTE: every combinational output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (NUM_LEDS > 1) begin
      if (!dir) begin
        if (pos == POS_LAST) begin
          dir_nxt = 1'b1;
          pos_nxt = pos - POS_W'(1);
        end else begin
          pos_nxt = pos + POS_W'(1);
        end
      end else begin
        if (pos == '0) begin
          dir_nxt = 1'b0;
          pos_nxt = pos + POS_W'(1);
        end else begin
          pos_nxt = pos - POS_W'(1);
        end
      end
    end
  end

  always_comb begin
    pat = bin;
    case (mode_q)
      MODE_SCAN: pat = NUM_LEDS'(1) << pos;
      MODE_GRAY: pat = bin ^ (bin >> 1);
      default:   pat = bin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= mode_e'(mode);
      bin     <= '0;
      pos     <= '0;
      dir     <= 1'b0;
      pwm_cnt <= '0;
      led     <= '0;
      tick    <= 1'b0;
    end else begin
      mode_q  <= mode_e'(mode);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      tick    <= adv;
      led     <= pat & {NUM_LEDS{pwm_on}};
      if (mode_change) begin
        bin <= '0;
        pos <= '0;
        dir <= 1'b0;
      end else if (adv) begin
        case (mode_q)
          MODE_SCAN: begin
            pos <= pos_nxt;
            dir <= dir_nxt;
          end
          MODE_BLINK: bin <= ~bin;
          default:    bin <= bin + NUM_LEDS'(1);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen. Three instances share stimulus:
//   dut_a : NUM_LEDS=4, TICK_CYCLES=5, PWM_BITS=3 (main)
//   dut_b : NUM_LEDS=1, TICK_CYCLES=5, PWM_BITS=3 (single LED)
//   dut_c : NUM_LEDS=4, TICK_CYCLES=1, PWM_BITS=3 (advance every enabled cycle)
// The reference model tracks the number of advances since the last restart
// and derives each pattern from that count in closed form.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       enable;
  logic       step;
  logic [3:0] bright;

  logic [3:0] led_a;
  logic       tick_a;
  logic [0:0] led_b;
  logic       tick_b;
  logic [3:0] led_c;
  logic       tick_c;

  int checks   = 0;
  int failures = 0;

  led_pattern_gen #(.NUM_LEDS(4), .TICK_CYCLES(5), .PWM_BITS(3)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .enable(enable), .step(step),
    .bright(bright), .led(led_a), .tick(tick_a));

  led_pattern_gen #(.NUM_LEDS(1), .TICK_CYCLES(5), .PWM_BITS(3)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .enable(enable), .step(step),
    .bright(bright), .led(led_b), .tick(tick_b));

  led_pattern_gen #(.NUM_LEDS(4), .TICK_CYCLES(1), .PWM_BITS(3)) dut_c (
    .clk(clk), .rst(rst), .mode(mode), .enable(enable), .step(step),
    .bright(bright), .led(led_c), .tick(tick_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int n;       // LED count
    int t;       // cycles per auto advance
    int k;       // advances since last reset / mode change
    int cnt;     // enabled cycles since last restart, modulo t
    int mode_q;
    int pwm;
    int led;
    int tick;
  } mdl_t;

  mdl_t m_a, m_b, m_c;

  function automatic int pat_of(input int n, input int md, input int k);
    int full, b, per, p;
    full = (1 << n) - 1;
    b    = k % (1 << n);
    case (md)
      1: begin
        if (n == 1) return 1;
        per = 2 * (n - 1);
        p   = k % per;
        return 1 << ((p < n) ? p : per - p);
      end
      2:       return (b ^ (b >> 1)) & full;
      3:       return (k % 2 == 1) ? full : 0;
      default: return b;
    endcase
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input logic r, input int md,
                                    input logic en, input logic st, input int br);
    int mc, adv;
    if (r) begin
      m.led = 0; m.tick = 0; m.cnt = 0; m.pwm = 0; m.k = 0; m.mode_q = md;
      return m;
    end
    mc  = (md != m.mode_q);
    adv = !mc && ((en && m.cnt == m.t - 1) || (st && !en));
    m.led  = (m.pwm < br) ? pat_of(m.n, m.mode_q, m.k) : 0;
    m.tick = adv;
    if (mc)      m.cnt = 0;
    else if (en) m.cnt = (m.cnt + 1) % m.t;
    if (mc)       m.k = 0;
    else if (adv) m.k = m.k + 1;
    m.mode_q = md;
    m.pwm    = (m.pwm + 1) % 8;
    return m;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the edge the DUT samples, then compare.
  task automatic cycle();
    @(posedge clk);
    m_a = mdl_step(m_a, rst, int'(mode), enable, step, int'(bright));
    m_b = mdl_step(m_b, rst, int'(mode), enable, step, int'(bright));
    m_c = mdl_step(m_c, rst, int'(mode), enable, step, int'(bright));
    #1;
    check("led_a",  16'(led_a),  16'(m_a.led));
    check("tick_a", 16'(tick_a), 16'(m_a.tick));
    check("led_b",  16'(led_b),  16'(m_b.led));
    check("tick_b", 16'(tick_b), 16'(m_b.tick));
    check("led_c",  16'(led_c),  16'(m_c.led));
    check("tick_c", 16'(tick_c), 16'(m_c.tick));
  endtask

  initial begin
    int n_tick, n_on, n_chg, guard;
    logic [3:0] prev;

    m_a = '{n: 4, t: 5, default: 0};
    m_b = '{n: 1, t: 5, default: 0};
    m_c = '{n: 4, t: 1, default: 0};
    rst = 1'b1; mode = 2'd0; enable = 1'b1; step = 1'b0; bright = 4'd8;

    // Reset and binary
    cycle(); cycle();
    check("reset_led", 16'(led_a), 16'h0);
    rst = 1'b0;
    n_tick = 0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (tick_a) n_tick++;
    end
    check("bin_ticks_80", 16'(n_tick), 16'd16);

    // Scan then gray
    mode = 2'd1;
    for (int i = 0; i < 45; i++) cycle();
    check("scan_n1_led", 16'(led_b), 16'h1);
    mode = 2'd2;
    for (int i = 0; i < 35; i++) cycle();

    // PWM on an all-ones blink pattern, held by pausing
    mode = 2'd3;
    cycle();
    enable = 1'b0; step = 1'b1;
    cycle();
    step = 1'b0; bright = 4'd3;
    cycle(); cycle();
    n_on = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (led_a == 4'hf) n_on++;
    end
    check("pwm_bright3", 16'(n_on), 16'd3);
    bright = 4'd0;
    cycle();
    n_on = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (led_a != 4'h0) n_on++;
    end
    check("pwm_bright0", 16'(n_on), 16'd0);
    bright = 4'd8;
    cycle();
    n_on = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (led_a == 4'hf) n_on++;
    end
    check("pwm_bright8", 16'(n_on), 16'd8);

    // Pause / step
    n_tick = 0; n_chg = 0; prev = led_a;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (tick_a) n_tick++;
      if (led_a != prev) n_chg++;
    end
    check("pause_ticks", 16'(n_tick), 16'd0);
    check("pause_led_changes", 16'(n_chg), 16'd0);
    step = 1'b1;
    cycle();
    step = 1'b0;
    n_tick = (tick_a) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (tick_a) n_tick++;
    end
    check("step_one_tick", 16'(n_tick), 16'd1);
    enable = 1'b1; step = 1'b1;
    n_tick = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (tick_a) n_tick++;
    end
    check("step_ignored_enabled", 16'(n_tick), 16'd1);
    step = 1'b0;

    // Mode change coinciding with an auto advance
    guard = 0;
    while (m_a.cnt != 4 && guard < 20) begin
      cycle();
      guard++;
    end
    mode = 2'd1;
    cycle();
    check("collide_no_tick", 16'(tick_a), 16'd0);
    n_tick = 0;
    do begin
      cycle();
      n_tick++;
    end while (!tick_a && n_tick < 20);
    check("collide_next_tick_gap", 16'(n_tick), 16'd5);

    // Reset mid-scan at pos=2
    guard = 0;
    while (m_a.k != 2 && guard < 20) begin
      cycle();
      guard++;
    end
    check("reach_scan_pos2", 16'(m_a.k < 2 ? 0 : 1), 16'd1);
    rst = 1'b1;
    cycle();
    check("midscan_reset_led", 16'(led_a), 16'h0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 3) != 0);
      step   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) bright = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
